// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-port round-robin sequencer in front of a byte-addressed data memory.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req/we/size/uns/addr/wdata 0,1  requester ports (0 = core LSU, 1 = debug/loader)
//   ack0/ack1, err0/err1, rdata     one-cycle completion pulse, error flag, load result
//   Mem_Read/Mem_Write/M_a          registered word-aligned memory strobes and address
//   Mem_WriteData/Mem_ReadData      memory write word / combinational read word
// Optional: define DMEM_CTRL_STATS_EN to add saturating stat_acc0/stat_acc1/stat_err counters.
module dmem_ctrl #(
   parameter int MEM_BYTES       = 16,
   parameter bit ERR_ON_MISALIGN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [1:0]  size0,
   input  logic [1:0]  size1,
   input  logic        uns0,
   input  logic        uns1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata,
   output logic        Mem_Read,
   output logic        Mem_Write,
   output logic [31:0] M_a,
   output logic [31:0] Mem_WriteData,
   input  logic [31:0] Mem_ReadData
`ifdef DMEM_CTRL_STATS_EN
   ,
   output logic [15:0] stat_acc0,
   output logic [15:0] stat_acc1,
   output logic [15:0] stat_err
`endif
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      r_state;
   logic        r_id;
   logic        r_last;
   logic        r_we;
   logic        r_uns;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        w_any;
   logic        w_gnt;
   logic        w_we;
   logic        w_uns;
   logic [1:0]  w_size;
   logic [31:0] w_addr_in;
   logic [31:0] w_wdata;
   logic        w_mis;
   logic [31:0] w_addr;
   logic [32:0] w_bytes;
   logic        w_err;

   // Shift the addressed lane down to bit 0, then zero- or sign-extend it.
   function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic u);
      logic [31:0] s;
      s = w >> {a, 3'b000};
      return sz == 2'b00 ? {{24{~u & s[7]}}, s[7:0]} :
             sz == 2'b01 ? {{16{~u & s[15]}}, s[15:0]} : s;
   endfunction

   // Replace the addressed byte (half = 0) or half (half = 1) lane of w with d.
   function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [1:0] a,
                                           input logic half, input logic [31:0] d);
      logic [31:0] m;
      m = (half ? 32'h0000_FFFF : 32'h0000_00FF) << {a, 3'b000};
      return (w & ~m) | ((d << {a, 3'b000}) & m);
   endfunction

   always_comb begin
      w_any     = req0 | req1;
      // On a tie the port that was not granted last wins.
      w_gnt     = (req0 & req1) ? ~r_last : req1;
      w_we      = w_gnt ? we1 : we0;
      w_uns     = w_gnt ? uns1 : uns0;
      w_size    = w_gnt ? size1 : size0;
      w_addr_in = w_gnt ? addr1 : addr0;
      w_wdata   = w_gnt ? wdata1 : wdata0;
      w_mis     = (w_size == 2'b01 & w_addr_in[0]) | (w_size == 2'b10 & |w_addr_in[1:0]);
      // With misalignment tolerated, the low bits are forced to the access's natural alignment.
      w_addr    = ERR_ON_MISALIGN ? w_addr_in :
                  {w_addr_in[31:2], w_size == 2'b10 ? 2'b00 :
                                    w_size == 2'b01 ? {w_addr_in[1], 1'b0} : w_addr_in[1:0]};
      w_bytes   = w_size == 2'b00 ? 33'd1 : w_size == 2'b01 ? 33'd2 : 33'd4;
      // 33-bit sum so addresses near 2^32 cannot wrap into range.
      w_err     = (&w_size) | (ERR_ON_MISALIGN & w_mis) |
                  (({1'b0, w_addr} + w_bytes) > 33'(MEM_BYTES));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_id          <= 1'b0;
         r_last        <= 1'b1;
         r_we          <= 1'b0;
         r_uns         <= 1'b0;
         r_size        <= 2'b00;
         r_addr        <= 32'd0;
         r_wdata       <= 32'd0;
         ack0          <= 1'b0;
         ack1          <= 1'b0;
         err0          <= 1'b0;
         err1          <= 1'b0;
         rdata         <= 32'd0;
         Mem_Read      <= 1'b0;
         Mem_Write     <= 1'b0;
         M_a           <= 32'd0;
         Mem_WriteData <= 32'd0;
      end else begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         rdata     <= 32'd0;
         Mem_Read  <= 1'b0;
         Mem_Write <= 1'b0;
         case (r_state)
            IDLE: if (w_any) begin
               r_id    <= w_gnt;
               r_last  <= w_gnt;
               r_we    <= w_we;
               r_uns   <= w_uns;
               r_size  <= w_size;
               r_addr  <= w_addr;
               r_wdata <= w_wdata;
               if (w_err) begin
                  r_state <= RESP;
                  ack0    <= ~w_gnt;
                  ack1    <= w_gnt;
                  err0    <= ~w_gnt;
                  err1    <= w_gnt;
               end else if (w_we && w_size == 2'b10) begin
                  r_state       <= WR;
                  Mem_Write     <= 1'b1;
                  M_a           <= {w_addr[31:2], 2'b00};
                  Mem_WriteData <= w_wdata;
               end else begin
                  r_state  <= RD;
                  Mem_Read <= 1'b1;
                  M_a      <= {w_addr[31:2], 2'b00};
               end
            end
            RD: if (r_we) begin
               // Sub-word store: merge the new lane(s) into the word just read.
               r_state       <= WR;
               Mem_Write     <= 1'b1;
               M_a           <= {r_addr[31:2], 2'b00};
               Mem_WriteData <= f_merge(Mem_ReadData, r_addr[1:0], r_size[0], r_wdata);
            end else begin
               r_state <= RESP;
               ack0    <= ~r_id;
               ack1    <= r_id;
               rdata   <= f_load(Mem_ReadData, r_addr[1:0], r_size, r_uns);
            end
            WR: begin
               r_state <= RESP;
               ack0    <= ~r_id;
               ack1    <= r_id;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_CTRL_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_acc0 <= 16'd0;
         stat_acc1 <= 16'd0;
         stat_err  <= 16'd0;
      end else begin
         if (ack0 && stat_acc0 != 16'hFFFF) stat_acc0 <= stat_acc0 + 16'd1;
         if (ack1 && stat_acc1 != 16'hFFFF) stat_acc1 <= stat_acc1 + 16'd1;
         if (((ack0 & err0) | (ack1 & err1)) && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized self-checking bench for dmem_ctrl against a byte-array reference model.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, uns0 = 1'b0, uns1 = 1'b0;
   logic [1:0]  size0 = 2'b00, size1 = 2'b00;
   logic [31:0] addr0 = 32'd0, addr1 = 32'd0, wdata0 = 32'd0, wdata1 = 32'd0;
   logic        ack0, ack1, err0, err1, Mem_Read, Mem_Write;
   logic [31:0] rdata, M_a, Mem_WriteData, Mem_ReadData;
`ifdef DMEM_CTRL_STATS_EN
   logic [15:0] stat_acc0, stat_acc1, stat_err;
`endif

   int n_chk = 0;
   int n_fail = 0;
   bit init = 1'b0;
   bit both_seen = 1'b0;
   bit mis_seen = 1'b0;
   int n_a0 = 0, n_a1 = 0, n_e = 0;

   logic [7:0] mem [0:15];
   logic [7:0] ref_mem [0:15];

   dmem_ctrl dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .size0(size0), .size1(size1), .uns0(uns0), .uns1(uns1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
      .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .M_a(M_a),
      .Mem_WriteData(Mem_WriteData), .Mem_ReadData(Mem_ReadData)
`ifdef DMEM_CTRL_STATS_EN
      , .stat_acc0(stat_acc0), .stat_acc1(stat_acc1), .stat_err(stat_err)
`endif
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write on the clock edge.
   always_comb begin
      Mem_ReadData = 32'd0;
      if (M_a < 32'd16)
         for (int i = 0; i < 4; i++) Mem_ReadData[8*i +: 8] = mem[{M_a[3:2], 2'(i)}];
   end

   always @(posedge clk) begin
      if (init) begin
         for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
      end else if (Mem_Write && M_a < 32'd16) begin
         for (int i = 0; i < 4; i++) mem[{M_a[3:2], 2'(i)}] <= Mem_WriteData[8*i +: 8];
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         n_a0 = 0;
         n_a1 = 0;
         n_e  = 0;
      end else begin
         if (Mem_Read && Mem_Write) both_seen = 1'b1;
         if ((Mem_Read || Mem_Write) && M_a[1:0] != 2'b00) mis_seen = 1'b1;
         if (ack0) n_a0++;
         if (ack1) n_a1++;
         if ((ack0 && err0) || (ack1 && err1)) n_e++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
   endfunction

   function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
      int n;
      if (sz == 2'b11) return 1'b1;
      n = nbytes(sz);
      if (longint'(a) % n != 0) return 1'b1;
      return longint'(a) + n > 16;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
      logic [31:0] v;
      int n;
      v = 32'd0;
      n = nbytes(sz);
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
      if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   function automatic logic [31:0] m_word(input logic [31:0] a);
      int b;
      b = int'(a) - int'(a) % 4;
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   task automatic drive(input bit p, input bit r, input bit we, input logic [1:0] sz,
                        input bit u, input logic [31:0] a, input logic [31:0] wd);
      if (p) begin
         req1 = r; we1 = we; size1 = sz; uns1 = u; addr1 = a; wdata1 = wd;
      end else begin
         req0 = r; we0 = we; size0 = sz; uns0 = u; addr0 = a; wdata0 = wd;
      end
   endtask

   // One isolated transaction on port p, checked against the reference model.
   task automatic xact(input bit p, input bit we, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd_o, output logic [31:0] wd_o);
      bit e, got;
      int n, nr, nw, lat, e_nr, e_nw;
      logic [31:0] e_rd, e_wd, ma_o;
      e = m_err(sz, a);
      e_rd = 32'd0;
      e_wd = 32'd0;
      if (e) begin
         lat = 1; e_nr = 0; e_nw = 0;
      end else if (!we) begin
         lat = 2; e_nr = 1; e_nw = 0;
         e_rd = m_load(a, sz, u);
      end else begin
         for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
         lat = sz == 2'b10 ? 2 : 3;
         e_nr = sz == 2'b10 ? 0 : 1;
         e_nw = 1;
         e_wd = m_word(a);
      end
      @(negedge clk);
      drive(p, 1'b1, we, sz, u, a, wd);
      n = 0; nr = 0; nw = 0; got = 1'b0;
      wd_o = 32'd0; ma_o = 32'd0; rd_o = 32'd0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (Mem_Read) begin nr++; ma_o = M_a; end
         if (Mem_Write) begin nw++; ma_o = M_a; wd_o = Mem_WriteData; end
         if (p ? ack1 : ack0) got = 1'b1;
      end
      chk("ack_seen", 32'(got), 32'd1);
      chk("latency", n, lat);
      chk("err", 32'(p ? err1 : err0), 32'(e));
      chk("rdata", rdata, e_rd);
      chk("other_ack", 32'(p ? ack0 : ack1), 32'd0);
      chk("n_read", nr, e_nr);
      chk("n_write", nw, e_nw);
      if (e_nw != 0) chk("wdata", wd_o, e_wd);
      if (e_nr + e_nw != 0) chk("m_a", ma_o, a & ~32'h3);
      rd_o = rdata;
      drive(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      logic [31:0] r, w, a;
      logic [1:0] sz;
      int k, cyc;
      logic [31:0] e0, e1;
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'($urandom);
      ref_mem[0] = 8'h02; ref_mem[1] = 8'h00; ref_mem[2] = 8'h00; ref_mem[3] = 8'h00;
      ref_mem[12] = 8'hC0; ref_mem[13] = 8'hD0; ref_mem[14] = 8'hE0; ref_mem[15] = 8'hF0;
      #1;
      chk("rst_ack0", 32'(ack0), 32'd0);
      chk("rst_ack1", 32'(ack1), 32'd0);
      chk("rst_err", 32'({err0, err1}), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_strobe", 32'({Mem_Read, Mem_Write}), 32'd0);
      chk("rst_m_a", M_a, 32'd0);
      chk("rst_wdata", Mem_WriteData, 32'd0);
      @(negedge clk); init = 1'b1;
      @(negedge clk); init = 1'b0; reset = 1'b0;

      xact(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, r, w);
      chk("spec_word_load", r, 32'h0000_0002);
      xact(1'b1, 1'b1, 2'b00, 1'b0, 32'd13, 32'h0000_0055, r, w);
      chk("spec_rmw_wdata", w, 32'hF0E0_55C0);
      xact(1'b0, 1'b0, 2'b00, 1'b0, 32'd13, 32'd0, r, w);
      chk("spec_byte_load", r, 32'h0000_0055);
      xact(1'b0, 1'b0, 2'b01, 1'b0, 32'd14, 32'd0, r, w);
      chk("spec_half_signed", r, 32'hFFFF_F0E0);
      xact(1'b1, 1'b0, 2'b01, 1'b1, 32'd14, 32'd0, r, w);
      chk("spec_half_uns", r, 32'h0000_F0E0);
      xact(1'b1, 1'b0, 2'b10, 1'b0, 32'd2, 32'd0, r, w);
      xact(1'b0, 1'b0, 2'b10, 1'b0, 32'd16, 32'd0, r, w);
      xact(1'b0, 1'b0, 2'b11, 1'b0, 32'd0, 32'd0, r, w);
      xact(1'b1, 1'b0, 2'b01, 1'b0, 32'd15, 32'd0, r, w);
      xact(1'b0, 1'b1, 2'b00, 1'b0, 32'd16, 32'hAB, r, w);
      xact(1'b1, 1'b1, 2'b10, 1'b0, 32'd6, 32'h1234_5678, r, w);
      xact(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'd0, r, w);
      xact(1'b1, 1'b1, 2'b01, 1'b0, 32'd2, 32'h0000_BEEF, r, w);

      for (int t = 0; t < 80; t++) begin
         sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                          : 32'($urandom_range(0, 19));
         xact(1'($urandom), 1'($urandom), sz, 1'($urandom), a, $urandom, r, w);
      end

      // Reset in the middle of a byte read-modify-write on port 0.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'd5, 32'h0000_00A5);
      cyc = 0;
      while (!Mem_Read && cyc < 10) begin @(negedge clk); cyc++; end
      chk("rmw_reached_rd", 32'(Mem_Read), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_strobe", 32'({Mem_Read, Mem_Write}), 32'd0);
      chk("mid_rst_ack", 32'({ack0, ack1, err0, err1}), 32'd0);
      chk("mid_rst_m_a", M_a, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk("mid_rst_mem", {24'd0, mem[5]}, {24'd0, ref_mem[5]});
      reset = 1'b0;

      // Contention: both ports request continuously; grants must alternate starting with port 0.
      e0 = m_load(32'd0, 2'b10, 1'b0);
      e1 = m_load(32'd12, 2'b01, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'd12, 32'd0);
      k = 0; cyc = 0;
      while (k < 6 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (ack0 || ack1) begin
            chk("cont_both_ack", 32'(ack0 & ack1), 32'd0);
            chk("cont_order", 32'(ack1), 32'(k % 2));
            chk("cont_rdata", rdata, ack1 ? e1 : e0);
            k++;
         end
      end
      chk("cont_acks", k, 6);
      drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      repeat (4) @(negedge clk);

      for (int i = 0; i < 16; i++) chk($sformatf("mem_%0d", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});
      chk("never_both_strobes", 32'(both_seen), 32'd0);
      chk("m_a_aligned", 32'(mis_seen), 32'd0);
`ifdef DMEM_CTRL_STATS_EN
      chk("stat_acc0", {16'd0, stat_acc0}, 32'(n_a0));
      chk("stat_acc1", {16'd0, stat_acc1}, 32'(n_a1));
      chk("stat_err", {16'd0, stat_err}, 32'(n_e));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
